// File: rtl/i2s_out.sv
// rtl/i2s_out.sv - I2S master transmitter for a 16-bit left/right sample pair
//
// Ports:
//   clock  in   system clock, all logic on posedge
//   reset  in   synchronous active-high reset
//   left   in   [15:0] left sample, captured only at frame start
//   right  in   [15:0] right sample, captured together with left
//   load   out  one-clock pulse when a sample pair is captured and a frame starts
//   i2s    out  [2:0] bus: [0]=bck, [1]=lrck (0=left, 1=right), [2]=data MSB first
//
// bck = clock/(2*DIVIDER); a frame is 2*SLOT bck periods. lrck and data only
// change on the clock where bck falls, so they are stable at the next rise.
module i2s_out #(
    parameter int DIVIDER = 4,
    parameter int SLOT    = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] left,
    input  logic [15:0] right,
    output logic        load,
    output logic [2:0]  i2s
);

    localparam int BCK      = 0;
    localparam int LRCK     = 1;
    localparam int DATA     = 2;
    localparam int SAMPLE_W = 16;

    localparam logic [7:0] CNT_MAX = 8'(DIVIDER - 1);
    localparam logic [6:0] POS_MAX = 7'(2 * SLOT - 1);
    localparam logic [6:0] SLOT_W  = 7'(SLOT);
    localparam logic [6:0] BITS_W  = 7'(SAMPLE_W);

    if (DIVIDER < 4 || DIVIDER > 255) begin : g_bad_divider
        $error("i2s_out: DIVIDER must be in 4..255");
    end
    if (SLOT < 17 || SLOT > 64) begin : g_bad_slot
        $error("i2s_out: SLOT must be in 17..64");
    end

    logic [7:0]          cnt;
    logic [6:0]          pos;
    logic                bck_q;
    logic                lrck_q;
    logic                data_q;
    logic                load_q;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;

    logic                fall;
    logic                right_slot;
    logic [6:0]          p;
    logic [3:0]          bit_idx;
    logic [SAMPLE_W-1:0] hold_ch;

    // A fall is the wrap of the divider while bck is high.
    assign fall       = (cnt == CNT_MAX) && bck_q;
    assign right_slot = (pos >= SLOT_W);
    assign p          = right_slot ? (pos - SLOT_W) : pos;
    // p=1 sends the MSB, p=16 sends bit 0; only used when p is in 1..16.
    assign bit_idx    = 4'(BITS_W - p);
    assign hold_ch    = right_slot ? hold_r : hold_l;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= 8'd0;
            pos    <= 7'd0;
            bck_q  <= 1'b0;
            lrck_q <= 1'b1;
            data_q <= 1'b0;
            load_q <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else begin
            load_q <= 1'b0;

            if (cnt == CNT_MAX) begin
                cnt   <= 8'd0;
                bck_q <= ~bck_q;
            end else begin
                cnt <= cnt + 8'd1;
            end

            if (fall) begin
                pos <= (pos == POS_MAX) ? 7'd0 : pos + 7'd1;

                if (p == 7'd0) begin
                    // Slot boundary: lrck leads the first data bit by one bck.
                    lrck_q <= right_slot;
                    data_q <= 1'b0;
                end else if (p <= BITS_W) begin
                    data_q <= hold_ch[bit_idx];
                end else begin
                    data_q <= 1'b0;
                end

                // Frame start; the left slot's first data bit is sent on the
                // next fall, so it already sees the freshly captured hold_l.
                if (pos == 7'd0) begin
                    hold_l <= left;
                    hold_r <= right;
                    load_q <= 1'b1;
                end
            end
        end
    end

    assign load      = load_q;
    assign i2s[BCK]  = bck_q;
    assign i2s[LRCK] = lrck_q;
    assign i2s[DATA] = data_q;

endmodule
